// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared ring constants and monitor state encoding
package ring_pkg;

    // Default geometry, shared with the ring counter that drives the monitor.
    localparam int RING_WIDTH = 8;
    localparam int RING_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_FAULT   = 2'd2
    } ring_state_e;

endpackage

// File: rtl/onehot_to_bin.sv
// rtl/onehot_to_bin.sv - combinational one-hot to binary encoder with one-hot validity
//
// Ports:
//   vec_i   WIDTH-bit input vector
//   idx_o   binary position of the set bit (meaningful only when valid_o)
//   valid_o high when exactly one bit of vec_i is set
module onehot_to_bin
    import ring_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH,
    parameter int IDX_W = RING_IDX_W
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // OR of the positions of all set bits: exact for a one-hot vector,
    // and small because no priority chain is needed.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
    end

    assign valid_o = ($countones(vec_i) == 1);

endmodule

// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - receive-side checker and decoder for a one-hot ring counter
//
// Optional build macro: RING_MON_STALL_EN (a repeated one-hot sample is a legal hold)
//
// Ports:
//   clk_i         system clock, rising edge
//   sys_rst_i     synchronous active-high reset
//   ring_i        sampled one-hot ring vector (bit i feeds bit i+1, MSB wraps to bit 0)
//   clr_err_i     clears err_cnt_o and fault_o (a simultaneous new fault wins)
//   index_o       registered binary position of the hot bit
//   locked_o      high while in LOCKED
//   fault_o       sticky fault flag
//   onehot_err_o  one-cycle pulse when a sample is not exactly one-hot
//   lap_cnt_o     completed rotations while locked
//   err_cnt_o     saturating fault count
module ring_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH    = RING_WIDTH,
    parameter int IDX_W    = RING_IDX_W,
    parameter int LOCK_CNT = 4,
    parameter int LAP_W    = 16,
    parameter int ERR_W    = 8
) (
    input  logic             clk_i,
    input  logic             sys_rst_i,
    input  logic [WIDTH-1:0] ring_i,
    input  logic             clr_err_i,
    output logic [IDX_W-1:0] index_o,
    output logic             locked_o,
    output logic             fault_o,
    output logic             onehot_err_o,
    output logic [LAP_W-1:0] lap_cnt_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    ring_state_e       state;
    logic [WIDTH-1:0]  prev_q;
    logic [GOOD_W-1:0] good_cnt;

    logic [IDX_W-1:0]  enc_idx;
    logic              onehot_ok;
    logic              advance;
    logic              hold;
    logic              step_ok;
    logic              new_fault;

    onehot_to_bin #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec_i   (ring_i),
        .idx_o   (enc_idx),
        .valid_o (onehot_ok)
    );

    // A legal advance is the previous sample rotated left by one.
    // prev_q is zero after reset, so the first sample can never advance.
    assign advance = onehot_ok && (ring_i == {prev_q[WIDTH-2:0], prev_q[WIDTH-1]});

`ifdef RING_MON_STALL_EN
    // Rings with a clock enable may repeat a position; that is a hold, not an error.
    assign hold = onehot_ok && (ring_i == prev_q);
`else
    assign hold = 1'b0;
`endif

    assign step_ok   = advance || hold;
    assign new_fault = (state == ST_LOCKED) && !step_ok;

    always_ff @(posedge clk_i) begin
        if (sys_rst_i) begin
            state        <= ST_ACQUIRE;
            prev_q       <= '0;
            good_cnt     <= '0;
            index_o      <= '0;
            locked_o     <= 1'b0;
            fault_o      <= 1'b0;
            onehot_err_o <= 1'b0;
            lap_cnt_o    <= '0;
            err_cnt_o    <= '0;
        end else begin
            prev_q       <= ring_i;
            onehot_err_o <= !onehot_ok;
            if (onehot_ok) begin
                index_o <= enc_idx;
            end

            case (state)
                ST_ACQUIRE: begin
                    if (advance) begin
                        if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                            state    <= ST_LOCKED;
                            locked_o <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end else if (!hold) begin
                        good_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (step_ok) begin
                        // Landing on bit 0 by an advance means the ring wrapped.
                        if (advance && ring_i[0]) begin
                            lap_cnt_o <= lap_cnt_o + 1'b1;
                        end
                    end else begin
                        state    <= ST_FAULT;
                        locked_o <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    // One dead cycle: the sample here is ignored for acquisition.
                    state    <= ST_ACQUIRE;
                    locked_o <= 1'b0;
                    good_cnt <= '0;
                end
                default: begin
                    state    <= ST_ACQUIRE;
                    locked_o <= 1'b0;
                    good_cnt <= '0;
                end
            endcase

            // A fault in the same cycle as a clear leaves exactly that one fault recorded.
            if (new_fault) begin
                fault_o <= 1'b1;
                if (clr_err_i) begin
                    err_cnt_o <= ERR_W'(1);
                end else if (err_cnt_o != '1) begin
                    err_cnt_o <= err_cnt_o + 1'b1;
                end
            end else if (clr_err_i) begin
                fault_o   <= 1'b0;
                err_cnt_o <= '0;
            end
        end
    end

endmodule
